// File: rtl/addsub_sequencer_64.sv
// addsub_sequencer_64: multi-cycle 64-bit add/subtract/accumulate sequencer
// wrapped around a ripple-carry adder. Operands are registered at acceptance,
// held for SETTLE_CYCLES clocks while the ripple path settles, then captured.
// Optional feature macro: ADDSUB_SAT_EN (signed saturation on overflow).

// 64-bit ripple-carry adder: a plain chain of full adders.
module RippleCarryAdder_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum,
  output logic        c_out
);

  localparam int unsigned W = 64;

  logic [W:0] carry;

  assign carry[0] = c_in;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[W];

endmodule

module addsub_sequencer_64 #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        c_out,
  output logic        overflow,
  output logic        zero,
  output logic        negative
);

  localparam int unsigned W     = 64;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             load_c;
  logic             capture_c;

  // Adder operand registers; the adder sees nothing else.
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic [1:0]   op_q;
  logic [W-1:0] acc;

  logic [W-1:0] sum_c;
  logic         carry_c;
  logic         ov_c;
  logic [W-1:0] res_c;

  RippleCarryAdder_64bit u_adder (
    .a     (x),
    .b     (y),
    .c_in  (cin),
    .sum   (sum_c),
    .c_out (carry_c)
  );

  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign ov_c = (x[W-1] == y[W-1]) && (sum_c[W-1] != x[W-1]);

`ifdef ADDSUB_SAT_EN
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  // Clamp toward the sign of X when an arithmetic op overflows.
  always_comb begin
    res_c = sum_c;
    if (ov_c && (op_q != OP_CLR)) begin
      res_c = x[W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign res_c = sum_c;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state decode plus operand-load and result-capture strobes.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    load_c    = 1'b0;
    capture_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load_c  = 1'b1;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          capture_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs registered from the next state so they track the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Operand formation at acceptance: subtract is A + ~B + 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x    <= '0;
      y    <= '0;
      cin  <= 1'b0;
      op_q <= OP_ADD;
    end else if (load_c) begin
      op_q <= op;
      unique case (op)
        OP_ADD: begin
          x   <= in_a;
          y   <= in_b;
          cin <= 1'b0;
        end
        OP_SUB: begin
          x   <= in_a;
          y   <= ~in_b;
          cin <= 1'b1;
        end
        OP_ACC: begin
          x   <= acc;
          y   <= in_a;
          cin <= 1'b0;
        end
        default: begin
          x   <= '0;
          y   <= '0;
          cin <= 1'b0;
        end
      endcase
    end
  end

  // Result, flag and accumulator capture at the end of the settle window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      acc      <= '0;
    end else if (capture_c) begin
      result   <= res_c;
      c_out    <= carry_c;
      overflow <= ov_c;
      zero     <= (res_c == '0);
      negative <= res_c[W-1];
      if (op_q == OP_ACC) begin
        acc <= res_c;
      end else if (op_q == OP_CLR) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_sequencer_64.sv
// Directed self-checking bench for addsub_sequencer_64 (settle window of 4).
module tb_addsub_sequencer_64;

  localparam int unsigned S = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        c_out;
  logic        overflow;
  logic        zero;
  logic        negative;

  int n_checks;
  int n_errors;

  addsub_sequencer_64 #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [63:0] r, input logic c,
                            input logic ov, input logic z, input logic n);
    check({tag, ".result"}, result, r);
    check({tag, ".c_out"}, 64'(c_out), 64'(c));
    check({tag, ".overflow"}, 64'(overflow), 64'(ov));
    check({tag, ".zero"}, 64'(zero), 64'(z));
    check({tag, ".negative"}, 64'(negative), 64'(n));
  endtask

  // Issue one request and wait for out_valid; leaves the DUT sitting in DONE.
  task automatic issue(input string tag, input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b);
    int n;
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op       = o;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(S));
  endtask

  // Let the consumer take the result.
  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] r, input logic c,
                     input logic ov, input logic z, input logic n);
    issue(tag, o, a, b);
    check_outs(tag, r, c, ov, z, n);
    release_result();
  endtask

  logic [63:0] exp_r;
  logic        exp_n;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'b00;
    in_a      = '0;
    in_b      = '0;
    #12;
    check_outs("reset", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run("add_carry", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    run("sub_borrow", 2'b01, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef ADDSUB_SAT_EN
    exp_r = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_n = 1'b0;
`else
    exp_r = 64'h8000_0000_0000_0000;
    exp_n = 1'b1;
`endif
    run("add_ovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, exp_r, 1'b0, 1'b1, 1'b0, exp_n);

`ifdef ADDSUB_SAT_EN
    exp_r = 64'h8000_0000_0000_0000;
    exp_n = 1'b1;
`else
    exp_r = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_n = 1'b0;
`endif
    run("sub_ovf", 2'b01, 64'h8000_0000_0000_0000, 64'd1, exp_r, 1'b1, 1'b1, 1'b0, exp_n);

    run("acc_clr", 2'b11, 64'h1234, 64'h5678, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    run("acc_10", 2'b10, 64'd10, 64'hDEAD, 64'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    run("acc_30", 2'b10, 64'd20, 64'hBEEF, 64'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    run("add_1p1", 2'b00, 64'd1, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run("acc_keep", 2'b10, 64'd0, 64'd99, 64'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    run("sub_nb", 2'b01, 64'd10, 64'd3, 64'd7, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure: hold DONE while the input side churns.
    issue("bp", 2'b00, 64'd3, 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      op       = 2'b10;
      in_a     = 64'(i * 1000 + 77);
      in_b     = 64'(i + 5);
      @(posedge clk);
      #1;
      check_outs("bp.hold", 64'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      check("bp.in_ready", 64'(in_ready), 64'd0);
      check("bp.out_valid", 64'(out_valid), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    @(negedge clk);
    check("bp.no_extra_valid", 64'(out_valid), 64'd0);
    check("bp.idle_ready", 64'(in_ready), 64'd1);
    // ACC must still be 30 if nothing was accepted during DONE.
    run("bp.acc", 2'b10, 64'd0, 64'd0, 64'd30, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during the second EXEC cycle discards the request and clears ACC.
    run("pre_rst", 2'b10, 64'd5, 64'd0, 64'd35, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    op       = 2'b10;
    in_a     = 64'd100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_outs("rst_mid", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid.in_ready", 64'(in_ready), 64'd1);
    check("rst_mid.out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 2 * S; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b1;
      check("rst_mid.no_valid", 64'(out_valid), 64'd0);
    end
    run("post_rst", 2'b10, 64'd3, 64'd0, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
